// File: rtl/inst_mem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the grant-state encoding, the chip-enable levels and the alignment helper.
package inst_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_IF   = 2'b01,
    ST_DBG  = 2'b10,
    ST_ERR  = 2'b11
  } arb_state_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   CNT_W        = 4;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_if.sv
// Fetch, debug and memory signals of the instruction-memory arbiter.
// The slave view belongs to the arbiter; the master view to its environment.
interface inst_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_inst;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_we;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_inst;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  if_req, if_addr, if_flush, dbg_req, dbg_addr, dbg_we, dbg_wdata, mem_inst,
    output if_stall, if_valid, if_inst, dbg_gnt, dbg_valid, dbg_rdata, dbg_err,
           mem_ce, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, dbg_req, dbg_addr, dbg_we, dbg_wdata, mem_inst,
    input  if_stall, if_valid, if_inst, dbg_gnt, dbg_valid, dbg_rdata, dbg_err,
           mem_ce, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Shares the async-read instruction memory between fetch and debug, with bounded debug priority.
// Optional program loading through the debug port is enabled by INST_ARB_LOAD_EN.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DBG_BURST = 4
) (
  input logic clk,
  input logic rst,
  inst_mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBG_BURST);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_pend;
  logic              r_if_flush;
  logic [DATA_W-1:0] r_if_inst;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_dbg_aligned;
  logic              w_if_gnt;
  logic              w_dbg_mem;
  logic              w_dbg_misal;
  logic              w_dbg_write;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_dbg_aligned = is_word_aligned(bus.dbg_addr[1:0]);

`ifdef INST_ARB_LOAD_EN
  assign w_dbg_write   = w_dbg_mem && bus.dbg_we;
  assign bus.mem_we    = w_dbg_write;
  assign bus.mem_wdata = w_dbg_write ? bus.dbg_wdata : '0;
`else
  logic w_unused_load;
  assign w_unused_load = ^{bus.dbg_we, bus.dbg_wdata};
  assign w_dbg_write   = 1'b0;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_wdata = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_if_gnt    = 1'b0;
    w_dbg_mem   = 1'b0;
    w_dbg_misal = 1'b0;
    if (rst) begin
      w_if_gnt    = bus.if_req && (!bus.dbg_req || !w_dbg_aligned || r_cnt == CNT_MAX);
      w_dbg_mem   = bus.dbg_req && w_dbg_aligned && !w_if_gnt;
      w_dbg_misal = bus.dbg_req && !w_dbg_aligned;
    end
  end

  always_comb begin
    w_mem_addr = '0;
    if (w_if_gnt)       w_mem_addr = bus.if_addr;
    else if (w_dbg_mem) w_mem_addr = bus.dbg_addr;
  end

  assign bus.mem_ce   = (w_if_gnt || w_dbg_mem) ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.mem_addr = w_mem_addr;
  assign bus.dbg_gnt  = w_dbg_mem || w_dbg_misal;
  assign bus.if_stall = rst && bus.if_req && !w_if_gnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_err_pend  <= 1'b0;
      r_if_flush  <= 1'b0;
      r_if_inst   <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_if_gnt)         r_state <= ST_IF;
      else if (w_dbg_mem)   r_state <= ST_DBG;
      else if (w_dbg_misal) r_state <= ST_ERR;
      else                  r_state <= ST_IDLE;

      // A misaligned request that lost to fetch is still answered next cycle.
      r_err_pend <= w_if_gnt && w_dbg_misal;
      r_if_flush <= bus.if_flush;

      if (w_if_gnt || !bus.if_req)              r_cnt <= '0;
      else if (w_dbg_mem && r_cnt != CNT_MAX)   r_cnt <= r_cnt + 1'b1;

      if (w_if_gnt && !bus.if_flush)   r_if_inst   <= bus.mem_inst;
      if (w_dbg_mem && !w_dbg_write)   r_dbg_rdata <= bus.mem_inst;
    end
  end

  assign bus.if_valid  = (r_state == ST_IF) && !r_if_flush;
  assign bus.dbg_valid = (r_state == ST_DBG) || (r_state == ST_ERR) || r_err_pend;
  assign bus.dbg_err   = (r_state == ST_ERR) || r_err_pend;
  assign bus.if_inst   = r_if_inst;
  assign bus.dbg_rdata = r_dbg_rdata;

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Shares the single-port asynchronous-read instruction memory between two requesters: pipeline fetch (IF stage) and a debug/program-loader port.
- Sits between the PC/IF stage, the debug unit and the instruction memory.
- Drives the memory chip-enable and address, registers the returned word, and raises a fetch stall when fetch loses arbitration.
- Bounded debug priority: fetch cannot starve.

Parameters:
- ADDR_W, 32, instruction address width (matches `InstAddrBus).
- DATA_W, 32, instruction word width (matches `InstBus).
- MAX_DBG_BURST, 4, maximum consecutive debug grants while fetch is pending; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address (PC).
- if_flush  in  1  discard the fetch response due next cycle.
- if_stall  out  1  fetch request not granted this cycle.
- if_valid  out  1  if_inst valid.
- if_inst  out  DATA_W  fetched instruction.
- dbg_req  in  1  debug access request.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_we  in  1  debug write; used only with the optional feature.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_valid  out  1  debug response valid.
- dbg_rdata  out  DATA_W  debug read data.
- dbg_err  out  1  debug response is an alignment error.
- mem_ce  out  1  memory chip enable (`ChipEnable / `ChipDisable).
- mem_addr  out  ADDR_W  memory byte address.
- mem_inst  in  DATA_W  memory read data, combinational from mem_addr.
- mem_we  out  1  memory write enable (optional feature).
- mem_wdata  out  DATA_W  memory write data (optional feature).

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=ST_IDLE, starvation counter=0.
  - if_valid, dbg_valid, dbg_err = 0.
  - if_inst, dbg_rdata = `ZeroWord.
  - While rst==0, combinational outputs are forced inactive: mem_ce=`ChipDisable, mem_addr=0, mem_we=0, dbg_gnt=0, if_stall=0.
- Reset asserted mid-operation aborts the in-flight response; no valid pulse follows.
- Grant decision is combinational each cycle:
  - Debug is "aligned" when dbg_addr[1:0]==0. A misaligned debug request is granted (dbg_gnt=1) but does not use the memory.
  - Fetch wins if if_req && (!dbg_req || dbg misaligned || cnt==MAX_DBG_BURST).
  - Otherwise an aligned dbg_req wins.
  - With neither request, nothing is granted and mem_ce=`ChipDisable.
- Memory drive:
  - Winner's address goes to mem_addr; mem_ce=`ChipEnable.
  - mem_inst is captured at the same clk edge into if_inst or dbg_rdata.
- if_stall = if_req && !fetch_granted.
- Starvation counter (4 bits):
  - Increments on each aligned debug grant while if_req==1.
  - Cleared on any fetch grant or whenever if_req==0.
  - Saturates at MAX_DBG_BURST.
- State register records last cycle's grant: ST_IDLE, ST_IF, ST_DBG, ST_ERR.
  - Next state = grant type this cycle: ST_ERR for a misaligned debug request, ST_IDLE when no grant.
  - A misaligned debug request and a fetch in the same cycle: fetch granted, state=ST_IF, and the error response is held as a pending flag, reported the next cycle.
- Responses, one cycle after the grant:
  - if_valid=1 in ST_IF unless if_flush was 1 in the grant cycle. A flushed response leaves if_valid=0 and if_inst unchanged.
  - dbg_valid=1 in ST_DBG; dbg_valid=dbg_err=1 in ST_ERR, with dbg_rdata unchanged.
  - Valid outputs are single-cycle pulses.
- Back-to-back grants are sustained: one access per cycle, no bubbles.
- Address is used as byte address; the memory indexes words itself.

Optional Feature:
- Macro `INST_ARB_LOAD_EN`.
- Defined:
  - An aligned debug grant with dbg_we=1 drives mem_we=1 and mem_wdata=dbg_wdata, enabling program loading.
  - Response is dbg_valid=1 with dbg_rdata unchanged.
  - While debug holds the port, if_stall is asserted as normal.
- Not defined:
  - mem_we tied 0, mem_wdata tied `ZeroWord.
  - dbg_we ignored; a write request is treated as a read.

Decomposition:
- Shared define.v additions: `InstAddrBus, `InstBus, `ChipEnable, `ChipDisable and `ZeroWord reused.
- New define.v entries: `ArbStBus [1:0], `ArbIdle 2'b00, `ArbIf 2'b01, `ArbDbg 2'b10, `ArbErr 2'b11, `ArbCntBus [3:0].
- No sub-module; counter and FSM stay inline (~200 lines).

Test Plan:
- Reset: rst=0 for 3 cycles with if_req=1 → mem_ce=0, if_stall=0, all valids 0; after release, if_addr=0x0 granted, if_valid=1 one cycle later, if_inst=mem word 0.
- Fetch stream: if_addr 0x0,0x4,0x8 in consecutive cycles → if_valid high 3 consecutive cycles, words 0,1,2, no stall.
- Contention, MAX_DBG_BURST=4: dbg_req and if_req held 10 cycles → grant pattern D,D,D,D,F,D,D,D,D,F; if_stall high exactly on D cycles.
- Misaligned: dbg_addr=0x6 alone → dbg_gnt=1, mem_ce=0, next cycle dbg_valid=1 and dbg_err=1. Same with if_req=1 → fetch granted, error reported the following cycle.
- Flush: if_req at 0x10 with if_flush=1 → next cycle if_valid=0 and if_inst keeps its prior value.
- With `INST_ARB_LOAD_EN: dbg_we=1, addr 0x20, data 0xDEADBEEF, then fetch 0x20 → mem_we pulses 1 cycle, if_inst=0xDEADBEEF.
